// File: rtl/issue_scheduler_param.sv
// Out-of-order issue window scheduler. It holds a window of IQ_DEPTH
// instructions and a captured RAW dependence matrix. Each cycle it picks at
// most one ready entry and binds it to the lowest free unit of its class.
// Per-unit countdown timers decide when an entry retires; retirement clears
// that entry's producer row so its dependants can become ready.
module issue_scheduler_param #(
  parameter int IQ_DEPTH  = 4,
  parameter int ALU_COUNT = 1,
  parameter int MUL_COUNT = 1,
  parameter int DIV_COUNT = 1,
  parameter int ALU_LAT   = 2,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 4,
  parameter int LAT_W     = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sch_enable,
  input  logic                         load,
  input  logic [IQ_DEPTH*IQ_DEPTH-1:0] raw_flat,
  input  logic [IQ_DEPTH-1:0]          valid_bits,
  input  logic [8*IQ_DEPTH-1:0]        instr_flat,
  output logic [IQ_DEPTH-1:0]          issue_onehot,
  output logic                         valid_out,
  output logic [7:0]                   issued_instr,
  output logic [1:0]                   issued_fu_type,
  output logic [1:0]                   issued_fu_index,
  output logic [IQ_DEPTH-1:0]          retire_onehot,
  output logic                         idle,
  output logic                         done
);

  localparam int N        = IQ_DEPTH;
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int UNITS    = ALU_COUNT + MUL_COUNT + DIV_COUNT;
  localparam int UW       = $clog2(UNITS + 1);
  localparam int MUL_BASE = ALU_COUNT;
  localparam int DIV_BASE = ALU_COUNT + MUL_COUNT;

  // Opcode [7:6] to class code: 00/01 ALU, 10 MUL, 11 DIV.
  function automatic logic [1:0] entry_class(input logic [1:0] op);
    logic [1:0] cls;
    case (op)
      2'b10:   cls = 2'd1;
      2'b11:   cls = 2'd2;
      default: cls = 2'd0;
    endcase
    return cls;
  endfunction

  // Latency loaded into a unit's counter, chosen by the unit's class range.
  function automatic logic [LAT_W-1:0] unit_lat(input int u);
    logic [LAT_W-1:0] lat;
    if (u < MUL_BASE)      lat = LAT_W'(ALU_LAT);
    else if (u < DIV_BASE) lat = LAT_W'(MUL_LAT);
    else                   lat = LAT_W'(DIV_LAT);
    return lat;
  endfunction

  // An entry never depends on itself, so diagonal bits are dropped on capture.
  function automatic logic [N*N-1:0] diag_mask();
    logic [N*N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i*N+i] = 1'b1;
    return m;
  endfunction

  logic                   active;
  logic [N*N-1:0]         raw_dyn;
  logic [N-1:0]           issued_mask;
  logic [N-1:0]           retired_mask;
  logic [IDX_W-1:0]       rr_ptr;
  logic [LAT_W-1:0]       cnt   [UNITS];
  logic [IDX_W-1:0]       owner [UNITS];

  logic [3:0]             class_free;
  logic [3:0][1:0]        class_unit;
  logic [N-1:0][1:0]      ent_class;
  logic [N-1:0]           dep_block;
  logic [N-1:0]           ready;
  logic                   found;
  logic [IDX_W-1:0]       sel_idx;
  logic [1:0]             sel_class;
  logic [UW-1:0]          bind_u;
  logic [IDX_W-1:0]       next_ptr;
  logic                   load_accept;
  logic                   issue_fire;
  logic [N-1:0]           retire_next;
  logic [N*N-1:0]         row_clear;

  // Per class: is any unit free (pre-edge counter zero), and the lowest one.
  always_comb begin
    class_free = '0;
    class_unit = '0;
    for (int i = ALU_COUNT - 1; i >= 0; i--)
      if (cnt[i] == '0) begin
        class_free[0] = 1'b1;
        class_unit[0] = 2'(i);
      end
    for (int i = MUL_COUNT - 1; i >= 0; i--)
      if (cnt[MUL_BASE+i] == '0) begin
        class_free[1] = 1'b1;
        class_unit[1] = 2'(i);
      end
    for (int i = DIV_COUNT - 1; i >= 0; i--)
      if (cnt[DIV_BASE+i] == '0) begin
        class_free[2] = 1'b1;
        class_unit[2] = 2'(i);
      end
  end

  // Readiness: valid, not yet issued, no live valid producer, class unit free.
  always_comb begin
    ent_class = '0;
    dep_block = '0;
    ready     = '0;
    for (int c = 0; c < N; c++) begin
      ent_class[c] = entry_class(instr_flat[8*c+6 +: 2]);
      for (int p = 0; p < N; p++)
        if (raw_dyn[p*N+c] && valid_bits[p]) dep_block[c] = 1'b1;
      ready[c] = active && valid_bits[c] && !issued_mask[c] && !dep_block[c]
                 && class_free[ent_class[c]];
    end
  end

  // Pick one ready entry: lowest index, or first at/after rr_ptr with wrap.
  always_comb begin
    int rot;
    rot     = 0;
    found   = 1'b0;
    sel_idx = '0;
    if (PRIO_MODE == 0) begin
      for (int i = N - 1; i >= 0; i--)
        if (ready[i]) begin
          found   = 1'b1;
          sel_idx = IDX_W'(i);
        end
    end else begin
      for (int off = N - 1; off >= 0; off--) begin
        rot = (int'(rr_ptr) + off) % N;
        if (ready[rot]) begin
          found   = 1'b1;
          sel_idx = IDX_W'(rot);
        end
      end
    end
  end

  // Issue decision, unit binding and the combinational selection output.
  always_comb begin
    load_accept  = load && idle;
    issue_fire   = found && sch_enable && !load_accept;
    issue_onehot = issue_fire ? (IQ_DEPTH'(1) << sel_idx) : '0;
    sel_class    = ent_class[sel_idx];
    case (sel_class)
      2'd1:    bind_u = UW'(MUL_BASE) + UW'(class_unit[1]);
      2'd2:    bind_u = UW'(DIV_BASE) + UW'(class_unit[2]);
      default: bind_u = UW'(class_unit[0]);
    endcase
    next_ptr = (int'(sel_idx) == N - 1) ? '0 : sel_idx + 1'b1;
  end

  // Units whose counter is about to go 1->0 retire their owning entry.
  always_comb begin
    retire_next = '0;
    row_clear   = '0;
    idle        = 1'b1;
    for (int u = 0; u < UNITS; u++) begin
      if (cnt[u] == LAT_W'(1)) retire_next[owner[u]] = 1'b1;
      if (cnt[u] != '0) idle = 1'b0;
    end
    for (int p = 0; p < N; p++)
      if (retire_next[p]) row_clear[p*N +: N] = '1;
    done = active && (&(retired_mask | ~valid_bits));
  end

  // Window state: capture on accepted load, then track issue and retirement.
  always_ff @(posedge clk) begin
    if (reset) begin
      active       <= 1'b0;
      raw_dyn      <= '0;
      issued_mask  <= '0;
      retired_mask <= '0;
      rr_ptr       <= '0;
    end else if (load_accept) begin
      active       <= 1'b1;
      raw_dyn      <= raw_flat & ~diag_mask();
      issued_mask  <= '0;
      retired_mask <= '0;
      rr_ptr       <= '0;
    end else begin
      if (issue_fire) begin
        issued_mask[sel_idx] <= 1'b1;
        rr_ptr               <= next_ptr;
      end
      retired_mask <= retired_mask | retire_next;
      raw_dyn      <= raw_dyn & ~row_clear;
    end
  end

  // Busy counters: load latency on bind, otherwise count down to zero.
  always_ff @(posedge clk) begin
    for (int u = 0; u < UNITS; u++) begin
      if (reset)
        cnt[u] <= '0;
      else if (issue_fire && bind_u == UW'(u))
        cnt[u] <= unit_lat(u);
      else if (cnt[u] != '0)
        cnt[u] <= cnt[u] - 1'b1;
    end
  end

  // Owning entry of each unit; only meaningful while its counter is nonzero.
  always_ff @(posedge clk) begin
    for (int u = 0; u < UNITS; u++)
      if (issue_fire && bind_u == UW'(u)) owner[u] <= sel_idx;
  end

  // Issue report: pulse valid_out, hold the last binding between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out       <= 1'b0;
      issued_instr    <= '0;
      issued_fu_type  <= '0;
      issued_fu_index <= '0;
    end else begin
      valid_out <= issue_fire;
      if (issue_fire) begin
        issued_instr    <= instr_flat[8*sel_idx +: 8];
        issued_fu_type  <= sel_class;
        issued_fu_index <= class_unit[sel_class];
      end
    end
  end

  // One-cycle retire pulse for every entry whose unit just finished.
  always_ff @(posedge clk) begin
    if (reset) retire_onehot <= '0;
    else       retire_onehot <= retire_next;
  end

endmodule

// File: tb/tb_issue_scheduler_param.sv
// Directed bench: default-parameter scheduler plus a round-robin, four-ALU one.
module tb_issue_scheduler_param;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          bad   = 0;

  logic        en0, load0, vo0, idle0, done0;
  logic [15:0] raw0;
  logic [3:0]  vb0, oh0, ro0;
  logic [31:0] instr0;
  logic [7:0]  ii0;
  logic [1:0]  ft0, fi0;

  logic        en1, load1, vo1, idle1, done1;
  logic [15:0] raw1;
  logic [3:0]  vb1, oh1, ro1;
  logic [31:0] instr1;
  logic [7:0]  ii1;
  logic [1:0]  ft1, fi1;

  always #5 clk = ~clk;

  issue_scheduler_param dut0 (
    .clk(clk), .reset(reset), .sch_enable(en0), .load(load0),
    .raw_flat(raw0), .valid_bits(vb0), .instr_flat(instr0),
    .issue_onehot(oh0), .valid_out(vo0), .issued_instr(ii0),
    .issued_fu_type(ft0), .issued_fu_index(fi0),
    .retire_onehot(ro0), .idle(idle0), .done(done0)
  );

  issue_scheduler_param #(.ALU_COUNT(4), .PRIO_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .sch_enable(en1), .load(load1),
    .raw_flat(raw1), .valid_bits(vb1), .instr_flat(instr1),
    .issue_onehot(oh1), .valid_out(vo1), .issued_instr(ii1),
    .issued_fu_type(ft1), .issued_fu_index(fi1),
    .retire_onehot(ro1), .idle(idle1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en0 = 1'b0; load0 = 1'b0; raw0 = '0; vb0 = '0; instr0 = '0;
    en1 = 1'b0; load1 = 1'b0; raw1 = '0; vb1 = '0; instr1 = '0;
    tick(); tick();
    chk("rst_vo", 32'(vo0), 0);
    chk("rst_ii", 32'(ii0), 0);
    chk("rst_ro", 32'(ro0), 0);
    chk("rst_idle", 32'(idle0), 1);
    chk("rst_done", 32'(done0), 0);
    chk("rst_oh", 32'(oh0), 0);
    chk("rst_idle1", 32'(idle1), 1);

    // Mixed classes, no dependences.
    reset = 1'b0; en0 = 1'b1; vb0 = 4'hF; instr0 = 32'hC4438201; raw0 = '0;
    load0 = 1'b1; #1;
    chk("A_oh_inactive", 32'(oh0), 0);
    tick(); load0 = 1'b0; #1;
    chk("A_oh_e0", 32'(oh0), 4'b0001);
    chk("A_done_e0", 32'(done0), 0);
    tick();
    chk("A_vo_e1", 32'(vo0), 1);
    chk("A_ii_e1", 32'(ii0), 8'h01);
    chk("A_ft_e1", 32'(ft0), 0);
    chk("A_fi_e1", 32'(fi0), 0);
    chk("A_oh_e1", 32'(oh0), 4'b0010);
    chk("A_idle_e1", 32'(idle0), 0);
    tick();
    chk("A_ii_e2", 32'(ii0), 8'h82);
    chk("A_ft_e2", 32'(ft0), 1);
    chk("A_oh_e2", 32'(oh0), 4'b1000);
    tick();
    chk("A_ii_e3", 32'(ii0), 8'hC4);
    chk("A_ft_e3", 32'(ft0), 2);
    chk("A_ro_e3", 32'(ro0), 4'b0001);
    chk("A_oh_e3", 32'(oh0), 4'b0100);
    tick();
    chk("A_ii_e4", 32'(ii0), 8'h43);
    chk("A_ft_e4", 32'(ft0), 0);
    chk("A_ro_e4", 32'(ro0), 0);
    chk("A_oh_e4", 32'(oh0), 0);
    tick();
    chk("A_vo_e5", 32'(vo0), 0);
    chk("A_ii_hold_e5", 32'(ii0), 8'h43);
    chk("A_ro_e5", 32'(ro0), 4'b0010);
    tick();
    chk("A_ro_e6", 32'(ro0), 4'b0100);
    chk("A_done_e6", 32'(done0), 0);
    tick();
    chk("A_ro_e7", 32'(ro0), 4'b1000);
    chk("A_done_e7", 32'(done0), 1);
    chk("A_idle_e7", 32'(idle0), 1);

    // All ALU, I1 depends on I0; a load while busy must be ignored.
    instr0 = 32'h13121110; raw0 = 16'h0002; vb0 = 4'hF; load0 = 1'b1; #1;
    chk("B_oh_pre", 32'(oh0), 0);
    tick(); load0 = 1'b0; #1;
    chk("B_oh_e0", 32'(oh0), 4'b0001);
    tick();
    chk("B_ii_e1", 32'(ii0), 8'h10);
    chk("B_oh_e1", 32'(oh0), 0);
    load0 = 1'b1; raw0 = '0; #1;
    tick(); load0 = 1'b0; #1;
    chk("B_vo_e2", 32'(vo0), 0);
    chk("B_oh_e2", 32'(oh0), 0);
    tick();
    chk("B_ro_e3", 32'(ro0), 4'b0001);
    chk("B_oh_e3", 32'(oh0), 4'b0010);
    tick();
    chk("B_vo_e4", 32'(vo0), 1);
    chk("B_ii_e4", 32'(ii0), 8'h11);
    tick(); tick();
    chk("B_ro_e6", 32'(ro0), 4'b0010);
    chk("B_oh_e6", 32'(oh0), 4'b0100);
    tick();
    chk("B_ii_e7", 32'(ii0), 8'h12);
    tick(); tick();
    chk("B_ro_e9", 32'(ro0), 4'b0100);
    chk("B_done_e9", 32'(done0), 0);
    tick();
    chk("B_ii_e10", 32'(ii0), 8'h13);
    tick(); tick();
    chk("B_ro_e12", 32'(ro0), 4'b1000);
    chk("B_done_e12", 32'(done0), 1);

    // I1 invalid, I2 depends on it; I1 and I3 never issue.
    raw0 = 16'h0040; vb0 = 4'b0101; load0 = 1'b1; #1;
    tick(); load0 = 1'b0; #1;
    chk("C_oh_e0", 32'(oh0), 4'b0001);
    chk("C_done_e0", 32'(done0), 0);
    tick();
    chk("C_ii_e1", 32'(ii0), 8'h10);
    tick(); tick();
    chk("C_ro_e3", 32'(ro0), 4'b0001);
    chk("C_oh_e3", 32'(oh0), 4'b0100);
    chk("C_done_e3", 32'(done0), 0);
    tick();
    chk("C_ii_e4", 32'(ii0), 8'h12);
    tick(); tick();
    chk("C_ro_e6", 32'(ro0), 4'b0100);
    chk("C_done_e6", 32'(done0), 1);
    chk("C_oh_e6", 32'(oh0), 0);

    // DIV in flight, then reset two cycles after its issue.
    raw0 = '0; vb0 = 4'b0001; instr0 = 32'h000000C0; load0 = 1'b1; #1;
    tick(); load0 = 1'b0; #1;
    chk("D_oh_e0", 32'(oh0), 4'b0001);
    tick();
    chk("D_vo_e1", 32'(vo0), 1);
    chk("D_ft_e1", 32'(ft0), 2);
    chk("D_ii_e1", 32'(ii0), 8'hC0);
    tick();
    reset = 1'b1; #1;
    tick();
    chk("D_vo_rst", 32'(vo0), 0);
    chk("D_ii_rst", 32'(ii0), 0);
    chk("D_ft_rst", 32'(ft0), 0);
    chk("D_ro_rst", 32'(ro0), 0);
    chk("D_idle_rst", 32'(idle0), 1);
    chk("D_done_rst", 32'(done0), 0);
    chk("D_oh_rst", 32'(oh0), 0);
    reset = 1'b0; #1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("D_ro_after", 32'(ro0), 0);
    end
    chk("D_idle_after", 32'(idle0), 1);

    // Round-robin, four ALUs, all independent.
    en1 = 1'b1; vb1 = 4'hF; instr1 = 32'h13121110; raw1 = '0; load1 = 1'b1; #1;
    tick(); load1 = 1'b0; #1;
    chk("E_oh_e0", 32'(oh1), 4'b0001);
    tick();
    chk("E_ii_e1", 32'(ii1), 8'h10);
    chk("E_fi_e1", 32'(fi1), 0);
    chk("E_oh_e1", 32'(oh1), 4'b0010);
    tick();
    chk("E_ii_e2", 32'(ii1), 8'h11);
    chk("E_fi_e2", 32'(fi1), 1);
    chk("E_oh_e2", 32'(oh1), 4'b0100);
    tick();
    chk("E_ii_e3", 32'(ii1), 8'h12);
    chk("E_fi_e3", 32'(fi1), 2);
    chk("E_oh_e3", 32'(oh1), 4'b1000);
    chk("E_ro_e3", 32'(ro1), 4'b0001);
    tick();
    chk("E_ii_e4", 32'(ii1), 8'h13);
    chk("E_fi_e4", 32'(fi1), 0);
    chk("E_oh_e4", 32'(oh1), 0);
    chk("E_ro_e4", 32'(ro1), 4'b0010);
    chk("E_rr_wrap", 32'(dut1.rr_ptr), 0);
    tick(); tick();
    chk("E_ro_e6", 32'(ro1), 4'b1000);
    chk("E_done_e6", 32'(done1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
